// File: rtl/mmc_sector_dma_seq.sv
// Sector-read DMA: Card Read, Flag poll until idle, then drain the buffer word by word into memory writes.
// Latency >= 3 cycles per word; requests hold stable while MMC/memory is busy; commands are ignored while busy.
module mmc_sector_dma_seq #(
    parameter int P_FLAG_BUSY_BIT = 0,
    parameter int P_POLL_MAX      = 4096,
    parameter int P_BUF_WORDS     = 128
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iCMD_VALID,
    output logic        oCMD_BUSY,
    input  logic [31:0] iCMD_SECTOR,
    input  logic [31:0] iCMD_MEM_ADDR,
    output logic        oDONE,
    output logic        oERROR,
    output logic        oMMC_REQ_VALID,
    input  logic        iMMC_REQ_BUSY,
    output logic        oMMC_REQ_RW,
    output logic [31:0] oMMC_REQ_ADDR,
    output logic [31:0] oMMC_REQ_DATA,
    input  logic        iMMC_RSP_VALID,
    input  logic [31:0] iMMC_RSP_DATA,
    output logic        oMEM_REQ_VALID,
    input  logic        iMEM_REQ_BUSY,
    output logic [31:0] oMEM_REQ_ADDR,
    output logic [31:0] oMEM_REQ_DATA
);

    localparam int               IDX_W      = (P_BUF_WORDS > 1) ? $clog2(P_BUF_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(P_BUF_WORDS - 1);
    localparam logic [12:0]      POLL_LIMIT = 13'(P_POLL_MAX);
    localparam logic [31:0]      ADDR_CMD   = 32'h0000_0004;
    localparam logic [31:0]      ADDR_FLAG  = 32'h0000_003C;
    localparam logic [31:0]      ADDR_BUF   = 32'h0000_0040;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_CMD_WAIT,
        S_POLL,
        S_POLL_WAIT,
        S_BUF,
        S_BUF_WAIT,
        S_MEM,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      sector_q;
    logic [31:0]      mem_base_q;
    logic [IDX_W-1:0] idx_q;
    logic [12:0]      poll_cnt_q;
    logic [31:0]      word_q;

    logic        latch_cmd;
    logic        idx_inc;
    logic        poll_inc;
    logic        word_load;
    logic [12:0] poll_cnt_nxt;
    logic [31:0] word_off;

    assign poll_cnt_nxt = poll_cnt_q + 13'd1;
    assign word_off     = 32'(idx_q) << 2;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state      <= S_IDLE;
            sector_q   <= '0;
            mem_base_q <= '0;
            idx_q      <= '0;
            poll_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            state <= state_nxt;
            if (latch_cmd) begin
                sector_q   <= iCMD_SECTOR;
                mem_base_q <= iCMD_MEM_ADDR;
                idx_q      <= '0;
                poll_cnt_q <= '0;
            end
            if (idx_inc) begin
                idx_q <= idx_q + 1'b1;
            end
            // Poll counter saturates so an oversized limit can never wrap back to zero.
            if (poll_inc && (poll_cnt_q != '1)) begin
                poll_cnt_q <= poll_cnt_nxt;
            end
            if (word_load) begin
                word_q <= iMMC_RSP_DATA;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        latch_cmd      = 1'b0;
        idx_inc        = 1'b0;
        poll_inc       = 1'b0;
        word_load      = 1'b0;
        oCMD_BUSY      = (state != S_IDLE);
        oDONE          = 1'b0;
        oERROR         = 1'b0;
        oMMC_REQ_VALID = 1'b0;
        oMMC_REQ_RW    = 1'b0;
        oMMC_REQ_ADDR  = '0;
        oMMC_REQ_DATA  = '0;
        oMEM_REQ_VALID = 1'b0;
        oMEM_REQ_ADDR  = '0;
        oMEM_REQ_DATA  = '0;

        case (state)
            S_IDLE: begin
                if (iCMD_VALID) begin
                    latch_cmd = 1'b1;
                    state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                oMMC_REQ_VALID = 1'b1;
                oMMC_REQ_RW    = 1'b1;
                oMMC_REQ_ADDR  = ADDR_CMD;
                oMMC_REQ_DATA  = sector_q;
                if (!iMMC_REQ_BUSY) state_nxt = S_CMD_WAIT;
            end
            S_CMD_WAIT: begin
                if (iMMC_RSP_VALID) state_nxt = S_POLL;
            end
            S_POLL: begin
                oMMC_REQ_VALID = 1'b1;
                oMMC_REQ_ADDR  = ADDR_FLAG;
                if (!iMMC_REQ_BUSY) state_nxt = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (iMMC_RSP_VALID) begin
                    if (!iMMC_RSP_DATA[P_FLAG_BUSY_BIT]) begin
                        state_nxt = S_BUF;
                    end else begin
                        poll_inc  = 1'b1;
                        state_nxt = (poll_cnt_nxt == POLL_LIMIT) ? S_ERR : S_POLL;
                    end
                end
            end
            S_BUF: begin
                oMMC_REQ_VALID = 1'b1;
                oMMC_REQ_ADDR  = ADDR_BUF + word_off;
                if (!iMMC_REQ_BUSY) state_nxt = S_BUF_WAIT;
            end
            S_BUF_WAIT: begin
                if (iMMC_RSP_VALID) begin
                    word_load = 1'b1;
                    state_nxt = S_MEM;
                end
            end
            S_MEM: begin
                oMEM_REQ_VALID = 1'b1;
                oMEM_REQ_ADDR  = mem_base_q + word_off;
                oMEM_REQ_DATA  = word_q;
                if (!iMEM_REQ_BUSY) begin
                    if (idx_q == IDX_LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = S_BUF;
                    end
                end
            end
            S_DONE: begin
                oDONE     = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                oERROR    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
